// File: rtl/bit_unstuffer_escape.sv
// rtl/bit_unstuffer_escape.sv - removes 0x00 stuffing after 0xFF from an MSB-first 32-bit byte stream
module bit_unstuffer_escape #(
    parameter logic [7:0] PAD_BYTE  = 8'h00,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 xclk,
    input  logic                 rst,
    input  logic [31:0]          din,
    input  logic [1:0]           bytes_in,
    input  logic                 flush_in,
    input  logic                 in_stb,
    output logic [31:0]          d_out,
    output logic [1:0]           bytes_out,
    output logic                 dv,
    output logic                 flush_out,
    output logic                 marker_stb,
    output logic [CNT_WIDTH-1:0] removed_cnt
);

    // Residual bytes (0..3) kept MSB-aligned; bytes beyond res_cnt_q are always zero.
    logic [23:0]          res_q, res_d;
    logic [1:0]           res_cnt_q, res_cnt_d;
    logic                 cry_q, cry_d;
    logic [31:0]          d_out_q, d_out_d;
    logic [1:0]           bytes_out_q, bytes_out_d;
    logic                 dv_q, dv_d;
    logic                 flush_p1_q, flush_p1_d;
    logic                 flush_out_q, flush_out_d;
    logic                 marker_q, marker_d;
    logic [CNT_WIDTH-1:0] removed_q, removed_d;

    // Scratch for the per-word scan: 7-byte accumulator (3 residual + 4 new).
    logic [7:0] acc [7];
    logic [2:0] cnt;
    logic [2:0] n_in;
    logic [2:0] rm;
    logic       cry;
    logic       keep;
    logic [7:0] b;

    // Next-state: flush has priority over in_stb; otherwise scan, compact and emit a word when 4 bytes are ready.
    always_comb begin
        res_d       = res_q;
        res_cnt_d   = res_cnt_q;
        cry_d       = cry_q;
        d_out_d     = d_out_q;
        bytes_out_d = bytes_out_q;
        dv_d        = 1'b0;
        marker_d    = 1'b0;
        removed_d   = removed_q;
        flush_p1_d  = flush_in;
        flush_out_d = flush_p1_q;

        for (int i = 0; i < 7; i++) begin
            acc[i] = 8'h00;
        end
        acc[0] = res_q[23:16];
        acc[1] = res_q[15:8];
        acc[2] = res_q[7:0];
        cnt    = {1'b0, res_cnt_q};
        n_in   = (bytes_in == 2'd0) ? 3'd4 : {1'b0, bytes_in};
        rm     = 3'd0;
        cry    = cry_q;
        keep   = 1'b0;
        b      = 8'h00;

        if (flush_in) begin
            if (res_cnt_q != 2'd0) begin
                d_out_d     = {res_q[23:16],
                               (res_cnt_q >= 2'd2) ? res_q[15:8] : PAD_BYTE,
                               (res_cnt_q == 2'd3) ? res_q[7:0]  : PAD_BYTE,
                               PAD_BYTE};
                bytes_out_d = res_cnt_q;
                dv_d        = 1'b1;
            end
            res_d     = 24'h0;
            res_cnt_d = 2'd0;
            cry_d     = 1'b0;
        end else if (in_stb) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < n_in) begin
                    b    = din[31-8*i -: 8];
                    keep = 1'b1;
                    if (cry) begin
                        if (b == 8'h00) begin
                            keep = 1'b0;
                            rm   = rm + 3'd1;
                            cry  = 1'b0;
                        end else if (b != 8'hFF) begin
                            marker_d = 1'b1;
                            cry      = 1'b0;
                        end
                    end else if (b == 8'hFF) begin
                        cry = 1'b1;
                    end
                    if (keep) begin
                        acc[cnt] = b;
                        cnt      = cnt + 3'd1;
                    end
                end
            end
            cry_d     = cry;
            removed_d = removed_q + CNT_WIDTH'(rm);
            if (cnt >= 3'd4) begin
                d_out_d     = {acc[0], acc[1], acc[2], acc[3]};
                bytes_out_d = 2'd0;
                dv_d        = 1'b1;
                res_d       = {acc[4], acc[5], acc[6]};
                res_cnt_d   = 2'(cnt - 3'd4);
            end else begin
                res_d     = {acc[0], acc[1], acc[2]};
                res_cnt_d = cnt[1:0];
            end
        end
    end

    // State and registered outputs; async reset discards any residual bytes.
    always_ff @(posedge xclk or posedge rst) begin
        if (rst) begin
            res_q       <= 24'h0;
            res_cnt_q   <= 2'd0;
            cry_q       <= 1'b0;
            d_out_q     <= 32'h0;
            bytes_out_q <= 2'd0;
            dv_q        <= 1'b0;
            flush_p1_q  <= 1'b0;
            flush_out_q <= 1'b0;
            marker_q    <= 1'b0;
            removed_q   <= '0;
        end else begin
            res_q       <= res_d;
            res_cnt_q   <= res_cnt_d;
            cry_q       <= cry_d;
            d_out_q     <= d_out_d;
            bytes_out_q <= bytes_out_d;
            dv_q        <= dv_d;
            flush_p1_q  <= flush_p1_d;
            flush_out_q <= flush_out_d;
            marker_q    <= marker_d;
            removed_q   <= removed_d;
        end
    end

    assign d_out       = d_out_q;
    assign bytes_out   = bytes_out_q;
    assign dv          = dv_q;
    assign flush_out   = flush_out_q;
    assign marker_stb  = marker_q;
    assign removed_cnt = removed_q;

endmodule

// File: doc/bit_unstuffer_escape.md
Name: bit_unstuffer_escape

Overview:
Removes the 0x00 stuffing byte that follows each 0xFF in a byte stream packed MSB-first into 32-bit words. This is the inverse of the JPEG bitstream escaper. It is used on the readback/decompress path and by self-check benches to recover the raw entropy-coded stream. A 0xFF followed by a byte other than 0x00 or 0xFF is reported as a marker and passed through unchanged. The block has no backpressure: removal only shrinks the stream, so output never falls behind input.

Parameters:
PAD_BYTE, 8'h00, fill value for unused LSB bytes of a partial (flush) output word
CNT_WIDTH, 16, width of the removed-byte statistics counter

Ports:
xclk  input  1  clock; all logic @xclk
rst  input  1  reset, asynchronous, active-high
din  input  32  input data, MSB aligned (byte 0 = din[31:24])
bytes_in  input  2  valid bytes in din, 0 means 4, 1 means din[31:24] only; valid @in_stb
flush_in  input  1  end of stream; din/bytes_in are ignored in this cycle
in_stb  input  1  din/bytes_in strobe
d_out  output  32  output data, MSB aligned
bytes_out  output  2  valid bytes in d_out, 0 means 4; valid @dv
dv  output  1  output word valid, single-cycle pulse per word
flush_out  output  1  flush delayed to match data latency
marker_stb  output  1  pulse: 0xFF followed by a byte other than 0x00/0xFF was seen
removed_cnt  output  CNT_WIDTH  number of 0x00 stuffing bytes removed; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, rst=1): the following all go to 0 immediately, regardless of xclk: d_out, bytes_out, dv, flush_out, marker_stb, removed_cnt, accumulator count, cry_ff, flush pipeline. A reset mid-word discards the residual bytes.
- Byte scan on in_stb: scan valid bytes MSB→LSB; cry_ff is the "previous byte was 0xFF" flag, carried across words.
  - Byte 0x00 with cry_ff=1: dropped; removed_cnt += 1; cry_ff←0.
  - Byte 0xFF with cry_ff=1: kept; cry_ff stays 1, so an 0xFF 0xFF fill sequence is kept intact.
  - Any other byte with cry_ff=1: kept; marker_stb pulses; cry_ff←0.
  - Byte 0xFF with cry_ff=0: kept; cry_ff←1.
  - Any other byte with cry_ff=0: kept.
- removed_cnt may increase by up to 2 per word.
- marker_stb is a single 1-cycle pulse at N+1 even if a word holds several markers; the bench must not rely on counting markers.
- Compaction: the kept bytes (0..4) are appended, in order, behind the residual bytes in a 7-byte accumulator (residual is 0..3).
- Output timing:
  - If the total after appending is ≥4, the 4 oldest bytes go to d_out at N+1 with dv=1 and bytes_out=0.
  - The remainder (0..3 bytes) stays as the new residual.
  - Otherwise dv=0 and the bytes stay in the accumulator.
  - Latency is fixed: in_stb@N → dv@N+1.
  - At most one output word per input word, so the accumulator never overflows; no stall logic is required.
- Flush: flush_in@N, independent of in_stb in the same cycle (flush has priority; din is ignored).
  - If residual = k > 0: dv@N+1, d_out carries the k bytes MSB-aligned, the LSBs are filled with PAD_BYTE, bytes_out=k.
  - If residual = 0: no dv.
  - flush_out@N+2 always.
  - cry_ff and the accumulator are cleared at N+1. A trailing 0xFF is output as-is, and a 0x00 arriving after the flush is not dropped.
- in_stb@N+1 (right after flush_in) is legal and starts a new stream from an empty accumulator.
- d_out and bytes_out hold their value when dv=0.
- removed_cnt is cleared only by rst.

Test Plan:
- No escapes: words 0x01020304, 0x05060708 (bytes_in=0) → dv@N+1 each cycle; d_out 0x01020304, 0x05060708; removed_cnt=0.
- In-word escape: 0x12FF0034, then 0x56789ABC → first dv d_out=0x12FF3456, residual 789ABC; flush → d_out=0x789ABC00, bytes_out=3, flush_out two cycles after flush_in; removed_cnt=1.
- Cross-word escape: 0xAABBCCFF, then 0x00112233 → d_out 0xAABBCCFF, then after flush 0x112233xx with bytes_out=3; removed_cnt=1.
- Double escape and fill: 0xFF00FF00, then 0xFFFF0001, then 0x02030405 → output stream FF FF FF FF 01 02 03 04 05; removed_cnt=3.
- Marker: 0x1234FFD9 then flush → marker_stb one pulse; dv d_out=0x1234FFD9; flush emits no dv; flush_out@N+2.
- Partial input and async reset: bytes_in=1 din=0xFF000000, then bytes_in=2 din=0x00770000 → residual FF 77. Assert rst asynchronously mid-stream → all outputs 0 immediately, with no xclk edge; a following flush produces no dv.
